multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath (shared instruction/data memory, IR, A/B, ALUOut, MDR regs).
//  Decodes IR opcode and sequences fetch/decode/execute/memory/writeback, stalling on a memory ready handshake.
//  Drives every datapath select/enable; counts retired instructions and flags illegal opcodes.
// PARAMETERS
//  CNT_WIDTH  32  width of RetiredCount
// PORTS
//  clk           in   1   system clock, rising edge
//  reset         in   1   asynchronous, active-low reset
//  Opcode        in   6   IR[31:26], stable from end of FETCH until next FETCH
//  Zero          in   1   ALU zero flag (combinational from current ALU op)
//  MemReady      in   1   memory completes current read/write this cycle
//  PCWrite       out  1   load PC (unconditional or resolved branch)
//  IorD          out  1   mem address: 0=PC, 1=ALUOut
//  MemRead       out  1   memory read request
//  MemWrite      out  1   memory write request
//  IRWrite       out  1   load IR from memory data
//  RegDst        out  2   0=rt, 1=rd, 2=r31
//  MemtoReg      out  2   0=ALUOut, 1=MDR, 2=PC, 3=LUI imm
//  RegWrite      out  1   register file write
//  ALUSrcA       out  1   0=PC, 1=A
//  ALUSrcB       out  3   0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2, 4=zero-ext imm
//  ALUOp         out  3   000 add, 001 sub, 010 use funct, 011 or, 100 and
//  PCSource      out  2   0=ALU result, 1=ALUOut, 2=jump addr {PC[31:28],IR[25:0],2'b00}
//  IllegalOp     out  1   sticky: unsupported opcode decoded
//  RetiredCount  out  CNT_WIDTH  instructions completed
//  State         out  4   current state (debug)
// BEHAVIOUR
//  States: IDLE0 FETCH1 DECODE2 MEMADR3 MEMRD4 MEMWB5 MEMWR6 REXEC7 RWB8 BRANCH9 JUMP10 IEXEC11 IWB12 LUIWB13 JAL14.
//  Reset low: State=IDLE, all control outputs 0, IllegalOp=0, RetiredCount=0. IDLE->FETCH on first clk after release.
//  Outputs are Moore decodes of State, except FETCH/MEMRD/MEMWR/BRANCH qualifiers listed below. Unlisted outputs = 0.
//  FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=add, PCSource=0; IRWrite=PCWrite=MemReady.
//    Stay while MemReady=0; MemReady=1 -> DECODE.
//  DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=add (branch target -> ALUOut). By Opcode:
//    00->REXEC; 23(lw)/2B(sw)->MEMADR; 04(beq)/05(bne)->BRANCH; 02->JUMP; 03->JAL;
//    08(addi)/0C(andi)/0D(ori)->IEXEC; 0F(lui)->LUIWB; other->FETCH, IllegalOp<=1, no count.
//  MEMADR: ALUSrcA=1, ALUSrcB=2, add. lw->MEMRD, sw->MEMWR.
//  MEMRD: MemRead=1, IorD=1; hold until MemReady, then MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
//  MEMWR: MemWrite=1, IorD=1; hold until MemReady, then FETCH (retire on exit).
//  REXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=010 -> RWB. RWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
//  IEXEC: ALUSrcA=1; addi: ALUSrcB=2, add; andi: ALUSrcB=4, and; ori: ALUSrcB=4, or -> IWB.
//    IWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
//  LUIWB: RegDst=0, MemtoReg=3, RegWrite=1 -> FETCH.
//  BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=sub, PCSource=1; PCWrite = beq?Zero:~Zero -> FETCH.
//  JUMP: PCSource=2, PCWrite=1 -> FETCH.
//  JAL: RegDst=2, MemtoReg=2 (PC already PC+4), RegWrite=1, PCSource=2, PCWrite=1 -> FETCH (same cycle write).
//  RetiredCount +1 on every transition into FETCH from a non-IDLE, non-DECODE state; wraps at 2^CNT_WIDTH-1 -> 0.
//  IllegalOp cleared only by reset. Stall any length on MemReady=0; no timeout.
//  Reset asserted mid-instruction: immediate IDLE, all outputs 0 same instant (no partial RegWrite/MemWrite).
//  Opcode/Zero sampled only in DECODE/BRANCH/MEMADR/IEXEC; changes elsewhere ignored.
// TESTING
//  Reset, MemReady=1, Opcode=00: IDLE,FETCH,DECODE,REXEC,RWB,FETCH; RegWrite=1 RegDst=1 only in RWB; RetiredCount=1.
//  lw with MemReady low 3 cycles in MEMRD: MemRead=1 IorD=1 held 4 cycles; MEMWB MemtoReg=1; count=1.
//  beq Zero=1 -> PCWrite=1 PCSource=1 in BRANCH; bne Zero=1 -> PCWrite=0; both retire.
//  jal: one JAL cycle with RegDst=2 MemtoReg=2 RegWrite=1 PCWrite=1 PCSource=2.
//  Opcode=3F: DECODE->FETCH, IllegalOp=1 sticky, count unchanged; reset clears it.
//  Reset low during MEMWR with MemReady=0: MemWrite drops immediately, State=IDLE, count=0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/mem/writeback, counts retired instructions, flags illegal opcodes.
module multicycle_control_fsm #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           Opcode,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           RegDst,
  output logic [1:0]           MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [2:0]           ALUSrcB,
  output logic [2:0]           ALUOp,
  output logic [1:0]           PCSource,
  output logic                 IllegalOp,
  output logic [CNT_WIDTH-1:0] RetiredCount,
  output logic [3:0]           State
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC,
    RWB, BRANCH, JUMP, IEXEC, IWB, LUIWB, JAL
  } state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
    OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
    OP_LW = 6'h23, OP_SW = 6'h2B;

  state_t state, nextState;
  logic retire;

  assign State = state;
  assign retire = (nextState == FETCH) && !(state inside {IDLE, FETCH, DECODE});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      IllegalOp    <= 1'b0;
      RetiredCount <= '0;
    end else begin
      state <= nextState;
      if (state == DECODE && nextState == FETCH) IllegalOp <= 1'b1;
      if (retire) RetiredCount <= RetiredCount + 1'b1;
    end
  end

  // Outputs are forced low while reset is held so no partial write leaks out.
  always_comb begin
    nextState = state;
    PCWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 2'd0;
    MemtoReg  = 2'd0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 3'd0;
    ALUOp     = 3'b000;
    PCSource  = 2'd0;
    if (reset) begin
      unique case (state)
        IDLE: nextState = FETCH;
        FETCH: begin
          MemRead   = 1'b1;
          ALUSrcB   = 3'd1;
          IRWrite   = MemReady;
          PCWrite   = MemReady;
          nextState = MemReady ? DECODE : FETCH;
        end
        DECODE: begin
          ALUSrcB = 3'd3;
          unique case (Opcode)
            OP_R:                    nextState = REXEC;
            OP_LW, OP_SW:            nextState = MEMADR;
            OP_BEQ, OP_BNE:          nextState = BRANCH;
            OP_J:                    nextState = JUMP;
            OP_JAL:                  nextState = JAL;
            OP_ADDI, OP_ANDI, OP_ORI: nextState = IEXEC;
            OP_LUI:                  nextState = LUIWB;
            default:                 nextState = FETCH;
          endcase
        end
        MEMADR: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = 3'd2;
          nextState = (Opcode == OP_SW) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          MemRead   = 1'b1;
          IorD      = 1'b1;
          nextState = MemReady ? MEMWB : MEMRD;
        end
        MEMWB: begin
          MemtoReg  = 2'd1;
          RegWrite  = 1'b1;
          nextState = FETCH;
        end
        MEMWR: begin
          MemWrite  = 1'b1;
          IorD      = 1'b1;
          nextState = MemReady ? FETCH : MEMWR;
        end
        REXEC: begin
          ALUSrcA   = 1'b1;
          ALUOp     = 3'b010;
          nextState = RWB;
        end
        RWB: begin
          RegDst    = 2'd1;
          RegWrite  = 1'b1;
          nextState = FETCH;
        end
        BRANCH: begin
          ALUSrcA   = 1'b1;
          ALUOp     = 3'b001;
          PCSource  = 2'd1;
          PCWrite   = (Opcode == OP_BEQ) ? Zero : ~Zero;
          nextState = FETCH;
        end
        JUMP: begin
          PCSource  = 2'd2;
          PCWrite   = 1'b1;
          nextState = FETCH;
        end
        IEXEC: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = (Opcode == OP_ADDI) ? 3'd2 : 3'd4;
          ALUOp     = (Opcode == OP_ANDI) ? 3'b100 : (Opcode == OP_ORI) ? 3'b011 : 3'b000;
          nextState = IWB;
        end
        IWB: begin
          RegWrite  = 1'b1;
          nextState = FETCH;
        end
        LUIWB: begin
          MemtoReg  = 2'd3;
          RegWrite  = 1'b1;
          nextState = FETCH;
        end
        JAL: begin
          RegDst    = 2'd2;
          MemtoReg  = 2'd2;
          RegWrite  = 1'b1;
          PCSource  = 2'd2;
          PCWrite   = 1'b1;
          nextState = FETCH;
        end
        default: nextState = IDLE;
      endcase
    end
  end
endmodule
